free_list_mw: RTL

//  Multi-wide physical-register free list for the rename stage. Allocates up to

---
 rtl/free_list_mw_if.sv | 43 ++++
 rtl/free_list_mw.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/free_list_mw_if.sv
// Rename-stage free list bundle: alloc, free, checkpoint and flush signals.
// master drives requests, slave (the free list) returns grants and status.
interface free_list_mw_if #(
  parameter int PHYS_REGS = 64,
  parameter int ALLOC_W   = 2,
  parameter int FREE_W    = 2,
  parameter int CKPT_N    = 4
);
  localparam int PHYS_W = $clog2(PHYS_REGS);
  localparam int CK_W   = $clog2(CKPT_N);
  localparam int CNT_W  = $clog2(PHYS_REGS + 1);

  logic [ALLOC_W-1:0]        alloc_req;
  logic                      alloc_ok;
  logic [ALLOC_W*PHYS_W-1:0] alloc_pd;
  logic [FREE_W-1:0]         free_valid;
  logic [FREE_W*PHYS_W-1:0]  free_pd;
  logic                      ckpt_take;
  logic                      ckpt_ready;
  logic [CK_W-1:0]           ckpt_id;
  logic                      ckpt_release;
  logic                      restore_valid;
  logic [CK_W-1:0]           restore_id;
  logic                      flush_valid;
  logic [CNT_W-1:0]          free_count;
  logic                      err_overflow;

  modport master (
    output alloc_req, free_valid, free_pd,
    output ckpt_take, ckpt_release,
    output restore_valid, restore_id, flush_valid,
    input  alloc_ok, alloc_pd, ckpt_ready,
    input  ckpt_id, free_count, err_overflow
  );

  modport slave (
    input  alloc_req, free_valid, free_pd,
    input  ckpt_take, ckpt_release,
    input  restore_valid, restore_id, flush_valid,
    output alloc_ok, alloc_pd, ckpt_ready,
    output ckpt_id, free_count, err_overflow
  );
endinterface

// File: rtl/free_list_mw.sv
// Multi-wide physical register free list with branch checkpoints.
// Ring of free PDs; head/tail carry a wrap bit, snapshots rewind head.
module free_list_mw #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int ALLOC_W   = 2,
  parameter int FREE_W    = 2,
  parameter int CKPT_N    = 4
) (
  input logic           clk,
  input logic           rst_n,
  free_list_mw_if.slave bus
);
  localparam int PHYS_W = $clog2(PHYS_REGS);
  localparam int PTR_W  = PHYS_W + 1;
  localparam int CK_W   = $clog2(CKPT_N);
  localparam int CNT_W  = $clog2(PHYS_REGS + 1);
  localparam int NFREE  = PHYS_REGS - ARCH_REGS;

  localparam logic [PTR_W-1:0] P_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] P_NFREE = PTR_W'(NFREE);
  localparam logic [CK_W-1:0]  K_ONE   = CK_W'(1);
  localparam logic [CK_W:0]    C_ONE   = (CK_W+1)'(1);
  localparam logic [CK_W:0]    C_FULL  = (CK_W+1)'(CKPT_N);

  logic [PHYS_W-1:0] ring_q [PHYS_REGS];
  logic [PTR_W-1:0]  snap_q [CKPT_N];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CK_W-1:0]  ck_head_q, ck_head_d;
  logic [CK_W-1:0]  ck_tail_q, ck_tail_d;
  logic [CK_W:0]    ck_cnt_q, ck_cnt_d;
  logic             err_q, err_d;

  logic [PTR_W-1:0]  fcnt, n_alloc, n_free;
  logic [PTR_W-1:0]  head_alloc, occ_d;
  logic [PHYS_W-1:0] f_idx [FREE_W];
  logic [ALLOC_W*PHYS_W-1:0] pd_bus;
  logic              alloc_ok, ck_ready;
  logic              take, rel;
  logic [CK_W-1:0]   rs_off;

  function automatic logic [PHYS_W-1:0] ring_init(int i);
    return (i < NFREE) ? PHYS_W'(ARCH_REGS + i) : '0;
  endfunction

  assign fcnt = tail_q - head_q;

  // lane k reads the slot past the requests of lower lanes
  always_comb begin : alloc_lanes
    logic [PHYS_W-1:0] idx;
    n_alloc = '0;
    pd_bus  = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      idx = head_q[PHYS_W-1:0] + n_alloc[PHYS_W-1:0];
      pd_bus[k*PHYS_W +: PHYS_W] = ring_q[idx];
      if (bus.alloc_req[k]) n_alloc = n_alloc + P_ONE;
    end
  end

  always_comb begin : free_lanes
    n_free = '0;
    for (int k = 0; k < FREE_W; k++) begin
      f_idx[k] = tail_q[PHYS_W-1:0] + n_free[PHYS_W-1:0];
      if (bus.free_valid[k]) n_free = n_free + P_ONE;
    end
  end

  assign alloc_ok = (fcnt >= n_alloc) &&
                    !bus.restore_valid && !bus.flush_valid;
  assign ck_ready = ck_cnt_q < C_FULL;
  assign take = bus.ckpt_take && ck_ready &&
                !bus.restore_valid && !bus.flush_valid;
  assign rel = bus.ckpt_release && (ck_cnt_q != '0);
  assign head_alloc = alloc_ok ? head_q + n_alloc : head_q;
  assign rs_off = bus.restore_id - ck_head_q;

  always_comb begin : next_state
    head_d    = head_alloc;
    tail_d    = tail_q + n_free;
    ck_head_d = rel ? ck_head_q + K_ONE : ck_head_q;
    ck_tail_d = take ? ck_tail_q + K_ONE : ck_tail_q;
    ck_cnt_d  = take ? ck_cnt_q + C_ONE : ck_cnt_q;
    if (bus.restore_valid) begin
      head_d    = snap_q[bus.restore_id];
      ck_tail_d = bus.restore_id + K_ONE;
      ck_cnt_d  = {1'b0, rs_off} + C_ONE;
    end
    if (rel) ck_cnt_d = ck_cnt_d - C_ONE;
    occ_d = tail_d - head_d;
    err_d = err_q | ((n_free != '0) && (occ_d > P_NFREE));
  end

  always_ff @(posedge clk or negedge rst_n) begin : ptr_reg
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= P_NFREE;
      ck_head_q <= '0;
      ck_tail_q <= '0;
      ck_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else if (bus.flush_valid) begin
      head_q    <= '0;
      tail_q    <= P_NFREE;
      ck_head_q <= '0;
      ck_tail_q <= '0;
      ck_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      ck_head_q <= ck_head_d;
      ck_tail_q <= ck_tail_d;
      ck_cnt_q  <= ck_cnt_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : ring_reg
    if (!rst_n) begin
      for (int i = 0; i < PHYS_REGS; i++) ring_q[i] <= ring_init(i);
    end else if (bus.flush_valid) begin
      for (int i = 0; i < PHYS_REGS; i++) ring_q[i] <= ring_init(i);
    end else begin
      for (int k = 0; k < FREE_W; k++) begin
        if (bus.free_valid[k])
          ring_q[f_idx[k]] <= bus.free_pd[k*PHYS_W +: PHYS_W];
      end
    end
  end

  // snapshot is the head after this cycle's grant
  always_ff @(posedge clk or negedge rst_n) begin : snap_reg
    if (!rst_n) begin
      for (int i = 0; i < CKPT_N; i++) snap_q[i] <= '0;
    end else if (take) begin
      snap_q[ck_tail_q] <= head_alloc;
    end
  end

  assign bus.alloc_ok     = alloc_ok;
  assign bus.alloc_pd     = pd_bus;
  assign bus.ckpt_ready   = ck_ready;
  assign bus.ckpt_id      = ck_tail_q;
  assign bus.free_count   = CNT_W'(fcnt);
  assign bus.err_overflow = err_q;

  a_restore_live : assert property (
    @(posedge clk) disable iff (!rst_n)
    (bus.restore_valid && !bus.flush_valid)
      |-> ({1'b0, rs_off} < ck_cnt_q)
  );
endmodule
